// File: rtl/read_core_arbiter.sv
// read_core_arbiter
//   Round-robin read-request arbiter and return router. Picks one requesting
//   core at a time, presents its read command to the backend, and records the
//   winner in an external core-number FIFO. Each returning read beat pops that
//   FIFO and routes a data-valid strobe to the core that issued the read.
//
//   state | meaning
//   IDLE  | arbitrate; launch a command when a request is pending and there is room
//   ISSUE | command held on o_cmd_*; waits for i_cmd_ready
//   GNT   | one-cycle grant pulse to the winner; no arbitration
//
// Ports
//   i_clk, i_rst_n          clock, async active-low reset
//   i_core_rd_req/addr      per-core request level and packed addresses
//   o_core_rd_gnt           one-hot grant pulse (GNT state)
//   o_cmd_valid/addr/core   backend command, i_cmd_ready accepts it
//   o_fifo_wr_en/wdata      push winner into core-number FIFO at acceptance
//   i_fifo_full/empty/rdata core-number FIFO status and head
//   o_fifo_rd_en            pop on a return beat when the FIFO holds an entry
//   i_rdata_valid/i_rdata   backend read beats (not stallable)
//   o_core_rdata_valid/data registered one-hot valid and broadcast data
//   o_outstanding           reads issued and not yet returned
//   o_err_underflow         sticky: a beat arrived with the FIFO empty
module read_core_arbiter #(
  parameter int NUM_CORES  = 4,
  parameter int CORE_ID_W  = 2,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 128,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [NUM_CORES-1:0]        i_core_rd_req,
  input  logic [NUM_CORES*ADDR_W-1:0] i_core_rd_addr,
  output logic [NUM_CORES-1:0]        o_core_rd_gnt,
  output logic                        o_cmd_valid,
  input  logic                        i_cmd_ready,
  output logic [ADDR_W-1:0]           o_cmd_addr,
  output logic [CORE_ID_W-1:0]        o_cmd_core,
  output logic                        o_fifo_wr_en,
  output logic [CORE_ID_W-1:0]        o_fifo_wdata,
  input  logic                        i_fifo_full,
  output logic                        o_fifo_rd_en,
  input  logic [CORE_ID_W-1:0]        i_fifo_rdata,
  input  logic                        i_fifo_empty,
  input  logic                        i_rdata_valid,
  input  logic [DATA_W-1:0]           i_rdata,
  output logic [NUM_CORES-1:0]        o_core_rdata_valid,
  output logic [DATA_W-1:0]           o_core_rdata,
  output logic [FIFO_DEPTH:0]         o_outstanding,
  output logic                        o_err_underflow
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GNT   = 2'd2
  } state_e;

  localparam logic [FIFO_DEPTH:0] OUT_MAX = {1'b1, {FIFO_DEPTH{1'b0}}};

  state_e                 state_q, state_d;
  logic [CORE_ID_W-1:0]   ptr_q, ptr_d;
  logic [CORE_ID_W-1:0]   cmd_core_q, cmd_core_d;
  logic [ADDR_W-1:0]      cmd_addr_q, cmd_addr_d;
  logic [FIFO_DEPTH:0]    outstanding_q, outstanding_d;
  logic [NUM_CORES-1:0]   rdata_valid_q, rdata_valid_d;
  logic [DATA_W-1:0]      rdata_q;
  logic                   err_q;

  logic                   win_found;
  logic [CORE_ID_W-1:0]   win_core;
  logic [ADDR_W-1:0]      win_addr;
  int                     arb_idx;
  logic                   accept;
  logic                   pop;

  // Rotating priority search starting at ptr_q.
  always_comb begin
    win_found = 1'b0;
    win_core  = '0;
    arb_idx   = 0;
    for (int i = 0; i < NUM_CORES; i++) begin
      arb_idx = (int'(ptr_q) + i) % NUM_CORES;
      if (!win_found && i_core_rd_req[arb_idx]) begin
        win_found = 1'b1;
        win_core  = CORE_ID_W'(arb_idx);
      end
    end
    win_addr = i_core_rd_addr[win_core*ADDR_W +: ADDR_W];
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cmd_core_d = cmd_core_q;
    cmd_addr_d = cmd_addr_q;
    accept     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_found && !i_fifo_full && (outstanding_q < OUT_MAX)) begin
          state_d    = ST_ISSUE;
          cmd_core_d = win_core;
          cmd_addr_d = win_addr;
        end
      end
      ST_ISSUE: begin
        if (i_cmd_ready) begin
          accept  = 1'b1;
          state_d = ST_GNT;
          if (int'(cmd_core_q) == NUM_CORES - 1) begin
            ptr_d = '0;
          end else begin
            ptr_d = cmd_core_q + 1'b1;
          end
        end
      end
      ST_GNT:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // A beat with an empty FIFO has no owner; it is dropped and flagged instead.
  assign pop = i_rdata_valid & ~i_fifo_empty;

  always_comb begin
    outstanding_d = outstanding_q;
    case ({accept, pop})
      2'b10:   outstanding_d = outstanding_q + 1'b1;
      2'b01:   outstanding_d = outstanding_q - 1'b1;
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_comb begin
    rdata_valid_d = '0;
    o_core_rd_gnt = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      rdata_valid_d[k] = pop && (i_fifo_rdata == CORE_ID_W'(k));
      o_core_rd_gnt[k] = (state_q == ST_GNT) && (cmd_core_q == CORE_ID_W'(k));
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= ST_IDLE;
      ptr_q         <= '0;
      cmd_core_q    <= '0;
      cmd_addr_q    <= '0;
      outstanding_q <= '0;
      rdata_valid_q <= '0;
      rdata_q       <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      cmd_core_q    <= cmd_core_d;
      cmd_addr_q    <= cmd_addr_d;
      outstanding_q <= outstanding_d;
      rdata_valid_q <= rdata_valid_d;
      if (pop) begin
        rdata_q <= i_rdata;
      end
      if (i_rdata_valid && i_fifo_empty) begin
        err_q <= 1'b1;
      end
    end
  end

  assign o_cmd_valid        = (state_q == ST_ISSUE);
  assign o_cmd_addr         = cmd_addr_q;
  assign o_cmd_core         = cmd_core_q;
  assign o_fifo_wr_en       = accept;
  assign o_fifo_wdata       = cmd_core_q;
  assign o_fifo_rd_en       = pop;
  assign o_core_rdata_valid = rdata_valid_q;
  assign o_core_rdata       = rdata_q;
  assign o_outstanding      = outstanding_q;
  assign o_err_underflow    = err_q;

endmodule

// File: tb/tb_read_core_arbiter.sv
// Testbench for read_core_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model (round-robin pick, queue of
// issued cores, outstanding count). The core-number FIFO is modelled here.
module tb_read_core_arbiter;
  localparam int NC = 4;
  localparam int AW = 32;
  localparam int DW = 128;

  logic            i_clk = 1'b0;
  logic            rst_n;
  logic [NC-1:0]   req;
  logic [NC*AW-1:0] core_addr;
  logic [NC-1:0]   gnt;
  logic            cmd_valid;
  logic            ready;
  logic [AW-1:0]   cmd_addr;
  logic [1:0]      cmd_core;
  logic            wr_en;
  logic [1:0]      wdata;
  logic            fifo_full;
  logic            rd_en;
  logic [1:0]      fifo_rdata;
  logic            fifo_empty;
  logic            rdv;
  logic [DW-1:0]   rdata;
  logic [NC-1:0]   core_rdv;
  logic [DW-1:0]   core_rdata;
  logic [4:0]      outstanding;
  logic            err;

  int total = 0;
  int bad   = 0;

  always #5 i_clk = ~i_clk;

  read_core_arbiter #(.NUM_CORES(4), .CORE_ID_W(2), .ADDR_W(32), .DATA_W(128), .FIFO_DEPTH(4)) dut (
    .i_clk(i_clk), .i_rst_n(rst_n),
    .i_core_rd_req(req), .i_core_rd_addr(core_addr), .o_core_rd_gnt(gnt),
    .o_cmd_valid(cmd_valid), .i_cmd_ready(ready), .o_cmd_addr(cmd_addr), .o_cmd_core(cmd_core),
    .o_fifo_wr_en(wr_en), .o_fifo_wdata(wdata), .i_fifo_full(fifo_full),
    .o_fifo_rd_en(rd_en), .i_fifo_rdata(fifo_rdata), .i_fifo_empty(fifo_empty),
    .i_rdata_valid(rdv), .i_rdata(rdata),
    .o_core_rdata_valid(core_rdv), .o_core_rdata(core_rdata),
    .o_outstanding(outstanding), .o_err_underflow(err)
  );

  // Core-number FIFO, 16 entries, registered flags, head visible directly.
  logic [1:0] fq[$];
  always @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      fq.delete();
      fifo_rdata <= 2'd0;
      fifo_empty <= 1'b1;
      fifo_full  <= 1'b0;
    end else begin
      if (rd_en && fq.size() > 0) void'(fq.pop_front());
      if (wr_en) fq.push_back(wdata);
      fifo_empty <= (fq.size() == 0);
      fifo_full  <= (fq.size() >= 16);
      fifo_rdata <= (fq.size() > 0) ? fq[0] : 2'd0;
    end
  end

  function automatic int rr(int p, logic [3:0] r);
    for (int i = 0; i < 4; i++) if (r[(p + i) % 4]) return (p + i) % 4;
    return -1;
  endfunction

  task automatic wait_edge();
    @(posedge i_clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; req = '0; ready = 1'b0; rdv = 1'b0; rdata = '0;
    repeat (2) wait_edge();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL reset_cmd_valid got=%0b exp=0", cmd_valid); end
    total++; if (cmd_addr !== '0) begin bad++; $display("FAIL reset_cmd_addr got=%h exp=0", cmd_addr); end
    total++; if (cmd_core !== 2'd0) begin bad++; $display("FAIL reset_cmd_core got=%0d exp=0", cmd_core); end
    total++; if (gnt !== 4'b0) begin bad++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
    total++; if (core_rdv !== 4'b0) begin bad++; $display("FAIL reset_rdv got=%b exp=0000", core_rdv); end
    total++; if (core_rdata !== '0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", core_rdata); end
    total++; if (outstanding !== 5'd0) begin bad++; $display("FAIL reset_outstanding got=%0d exp=0", outstanding); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b exp=0", err); end
    total++; if (wr_en !== 1'b0 || rd_en !== 1'b0) begin bad++; $display("FAIL reset_fifo_en got=%0b%0b exp=00", wr_en, rd_en); end
  endtask

  task automatic test_single_read();
    apply_reset();
    ready = 1'b1;
    core_addr[2*AW +: AW] = 32'h100;
    req = 4'b0100;
    wait_edge();
    total++; if (cmd_valid !== 1'b1 || cmd_addr !== 32'h100 || cmd_core !== 2'd2)
      begin bad++; $display("FAIL single_cmd got=%0b/%h/%0d exp=1/100/2", cmd_valid, cmd_addr, cmd_core); end
    total++; if (wr_en !== 1'b1 || wdata !== 2'd2) begin bad++; $display("FAIL single_push got=%0b/%0d exp=1/2", wr_en, wdata); end
    req = 4'b0000;
    wait_edge();
    total++; if (gnt !== 4'b0100 || cmd_valid !== 1'b0 || wr_en !== 1'b0)
      begin bad++; $display("FAIL single_gnt got=%b/%0b/%0b exp=0100/0/0", gnt, cmd_valid, wr_en); end
    total++; if (outstanding !== 5'd1) begin bad++; $display("FAIL single_out1 got=%0d exp=1", outstanding); end
    wait_edge();
    total++; if (gnt !== 4'b0) begin bad++; $display("FAIL single_gnt_len got=%b exp=0000", gnt); end
    rdv = 1'b1; rdata = 128'hAB;
    #1;
    total++; if (rd_en !== 1'b1) begin bad++; $display("FAIL single_pop got=%0b exp=1", rd_en); end
    wait_edge();
    rdv = 1'b0;
    total++; if (core_rdv !== 4'b0100 || core_rdata !== 128'hAB)
      begin bad++; $display("FAIL single_ret got=%b/%h exp=0100/ab", core_rdv, core_rdata); end
    total++; if (outstanding !== 5'd0) begin bad++; $display("FAIL single_out0 got=%0d exp=0", outstanding); end
    wait_edge();
    total++; if (core_rdv !== 4'b0) begin bad++; $display("FAIL single_rdv_len got=%b exp=0000", core_rdv); end
  endtask

  task automatic test_round_robin();
    int p;
    int w;
    int got;
    int n;
    apply_reset();
    ready = 1'b1; req = 4'hF; p = 0; got = 0;
    for (n = 0; n < 60 && got < 6; n++) begin
      wait_edge();
      if (gnt != 4'b0) begin
        w = rr(p, 4'hF);
        p = (w + 1) % 4;
        total++; if (gnt !== 4'(1 << w)) begin bad++; $display("FAIL rr_order idx=%0d got=%b exp=%b", got, gnt, 4'(1 << w)); end
        got++;
      end
    end
    total++; if (got != 6) begin bad++; $display("FAIL rr_timeout got=%0d exp=6 grants", got); end
    req = 4'h0;
  endtask

  task automatic test_backpressure();
    logic [31:0] a;
    int pushes;
    int gnts;
    apply_reset();
    a = $urandom;
    ready = 1'b0; core_addr[1*AW +: AW] = a; req = 4'b0010;
    wait_edge();
    total++; if (cmd_valid !== 1'b1 || cmd_core !== 2'd1 || cmd_addr !== a)
      begin bad++; $display("FAIL bp_launch got=%0b/%0d/%h exp=1/1/%h", cmd_valid, cmd_core, cmd_addr, a); end
    req = 4'b1011; core_addr[1*AW +: AW] = ~a; core_addr[0 +: AW] = $urandom;
    for (int i = 0; i < 5; i++) begin
      wait_edge();
      total++; if (cmd_valid !== 1'b1 || cmd_core !== 2'd1 || cmd_addr !== a || wr_en !== 1'b0 || gnt !== 4'b0)
        begin bad++; $display("FAIL bp_hold cyc=%0d got=%0b/%0d/%h/%0b/%b exp=1/1/%h/0/0000", i, cmd_valid, cmd_core, cmd_addr, wr_en, gnt, a); end
    end
    ready = 1'b1;
    #1;
    pushes = wr_en ? 1 : 0;
    gnts = 0;
    req = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      wait_edge();
      if (wr_en) pushes++;
      if (gnt == 4'b0010) gnts++;
      else if (gnt != 4'b0) gnts += 10;
    end
    total++; if (pushes != 1 || gnts != 1) begin bad++; $display("FAIL bp_release got pushes=%0d gnts=%0d exp=1/1", pushes, gnts); end
    total++; if (outstanding !== 5'd1) begin bad++; $display("FAIL bp_out got=%0d exp=1", outstanding); end
  endtask

  task automatic test_outstanding_limit();
    int pushes;
    int n;
    logic [DW-1:0] d;
    apply_reset();
    ready = 1'b1; req = 4'hF; pushes = 0;
    for (n = 0; n < 200 && pushes < 16; n++) begin
      wait_edge();
      if (wr_en) pushes++;
    end
    total++; if (pushes != 16) begin bad++; $display("FAIL lim_fill got=%0d exp=16", pushes); end
    wait_edge();
    total++; if (outstanding !== 5'd16) begin bad++; $display("FAIL lim_out got=%0d exp=16", outstanding); end
    for (int i = 0; i < 8; i++) begin
      wait_edge();
      total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL lim_block cyc=%0d got=%0b exp=0", i, cmd_valid); end
    end
    d = {$urandom, $urandom, $urandom, $urandom};
    rdv = 1'b1; rdata = d;
    wait_edge();
    rdv = 1'b0;
    total++; if (core_rdv !== 4'b0001 || core_rdata !== d || outstanding !== 5'd15)
      begin bad++; $display("FAIL lim_ret got=%b/%0d exp=0001/15", core_rdv, outstanding); end
    for (n = 0; n < 10 && !cmd_valid; n++) wait_edge();
    total++; if (cmd_valid !== 1'b1 || cmd_core !== 2'd0)
      begin bad++; $display("FAIL lim_resume got=%0b/%0d exp=1/0", cmd_valid, cmd_core); end
    req = 4'h0;
  endtask

  task automatic test_out_of_order();
    int order[3] = '{3, 1, 0};
    int rets[3]  = '{1, 0, 2};
    logic [DW-1:0] d;
    int n;
    apply_reset();
    ready = 1'b1;
    foreach (order[j]) begin
      req = 4'(1 << order[j]);
      for (n = 0; n < 10 && gnt == 4'b0; n++) wait_edge();
      total++; if (gnt !== 4'(1 << order[j])) begin bad++; $display("FAIL ooo_gnt idx=%0d got=%b exp=%b", j, gnt, 4'(1 << order[j])); end
      req = 4'b0;
      wait_edge();
    end
    total++; if (outstanding !== 5'd3) begin bad++; $display("FAIL ooo_out3 got=%0d exp=3", outstanding); end
    req = 4'b0100;
    for (n = 0; n < 10 && !cmd_valid; n++) wait_edge();
    d = {$urandom, $urandom, $urandom, $urandom};
    rdv = 1'b1; rdata = d;
    wait_edge();
    rdv = 1'b0; req = 4'b0;
    total++; if (core_rdv !== 4'b1000 || core_rdata !== d || gnt !== 4'b0100)
      begin bad++; $display("FAIL ooo_same_cycle got=%b/%b exp=1000/0100", core_rdv, gnt); end
    total++; if (outstanding !== 5'd3) begin bad++; $display("FAIL ooo_out_same got=%0d exp=3", outstanding); end
    foreach (rets[j]) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      rdv = 1'b1; rdata = d;
      wait_edge();
      total++; if (core_rdv !== 4'(1 << rets[j]) || core_rdata !== d)
        begin bad++; $display("FAIL ooo_ret idx=%0d got=%b exp=%b", j, core_rdv, 4'(1 << rets[j])); end
    end
    rdv = 1'b0;
    total++; if (outstanding !== 5'd0) begin bad++; $display("FAIL ooo_out0 got=%0d exp=0", outstanding); end
  endtask

  task automatic test_underflow_reset();
    int n;
    logic [31:0] a1;
    apply_reset();
    rdv = 1'b1; rdata = {4{$urandom}};
    #1;
    total++; if (rd_en !== 1'b0) begin bad++; $display("FAIL uf_pop got=%0b exp=0", rd_en); end
    wait_edge();
    rdv = 1'b0;
    total++; if (core_rdv !== 4'b0 || err !== 1'b1) begin bad++; $display("FAIL uf_flag got=%b/%0b exp=0000/1", core_rdv, err); end
    repeat (3) wait_edge();
    total++; if (err !== 1'b1) begin bad++; $display("FAIL uf_sticky got=%0b exp=1", err); end
    ready = 1'b1; req = 4'b0010;
    for (n = 0; n < 10 && gnt == 4'b0; n++) wait_edge();
    req = 4'b0; ready = 1'b0;
    wait_edge();
    req = 4'b0100;
    for (n = 0; n < 10 && !cmd_valid; n++) wait_edge();
    total++; if (cmd_valid !== 1'b1 || cmd_core !== 2'd2) begin bad++; $display("FAIL rst_pre got=%0b/%0d exp=1/2", cmd_valid, cmd_core); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (cmd_valid !== 1'b0 || cmd_addr !== '0 || cmd_core !== 2'd0 || gnt !== 4'b0)
      begin bad++; $display("FAIL rst_mid_cmd got=%0b/%h/%0d/%b exp=0/0/0/0000", cmd_valid, cmd_addr, cmd_core, gnt); end
    total++; if (core_rdv !== 4'b0 || core_rdata !== '0 || outstanding !== 5'd0 || err !== 1'b0)
      begin bad++; $display("FAIL rst_mid_ret got=%b/%0d/%0b exp=0000/0/0", core_rdv, outstanding, err); end
    wait_edge();
    a1 = $urandom;
    core_addr[1*AW +: AW] = a1;
    rst_n = 1'b1; ready = 1'b1; req = 4'b1010;
    for (n = 0; n < 10 && !cmd_valid; n++) wait_edge();
    total++; if (cmd_valid !== 1'b1 || cmd_core !== 2'd1 || cmd_addr !== a1)
      begin bad++; $display("FAIL rst_ptr got=%0b/%0d exp=1/1", cmd_valid, cmd_core); end
    req = 4'b0;
  endtask

  task automatic test_random();
    logic [1:0]    mq[$];
    int            mptr, mout, w;
    logic [3:0]    exp_rdv, exp_gnt, req_snap;
    logic [DW-1:0] exp_rdata;
    logic          exp_err, prev_valid, prev_acc, exp_wr, exp_rd;
    logic [1:0]    cur_core;
    logic [31:0]   cur_addr;
    logic [NC*AW-1:0] addr_snap;
    apply_reset();
    mptr = 0; mout = 0; exp_rdv = '0; exp_rdata = '0; exp_err = 1'b0;
    prev_valid = 1'b0; prev_acc = 1'b0; cur_core = '0; cur_addr = '0;
    for (int k = 0; k < NC; k++) core_addr[k*AW +: AW] = $urandom;
    req = 4'($urandom_range(0, 15));
    req_snap = req; addr_snap = core_addr;
    for (int cyc = 0; cyc < 600; cyc++) begin
      wait_edge();
      exp_gnt = prev_acc ? 4'(1 << cur_core) : 4'b0;
      total++; if (gnt !== exp_gnt) begin bad++; $display("FAIL rnd_gnt cyc=%0d got=%b exp=%b", cyc, gnt, exp_gnt); end
      total++; if (core_rdv !== exp_rdv) begin bad++; $display("FAIL rnd_rdv cyc=%0d got=%b exp=%b", cyc, core_rdv, exp_rdv); end
      if (exp_rdv != 4'b0) begin
        total++; if (core_rdata !== exp_rdata) begin bad++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", cyc, core_rdata, exp_rdata); end
      end
      total++; if (err !== exp_err) begin bad++; $display("FAIL rnd_err cyc=%0d got=%0b exp=%0b", cyc, err, exp_err); end
      total++; if (outstanding !== 5'(mout)) begin bad++; $display("FAIL rnd_out cyc=%0d got=%0d exp=%0d", cyc, outstanding, mout); end
      for (int k = 0; k < NC; k++) begin
        if (exp_gnt[k]) begin
          req[k] = 1'($urandom_range(0, 1));
          core_addr[k*AW +: AW] = $urandom;
        end else if (!req[k] && $urandom_range(0, 3) == 0) begin
          req[k] = 1'b1;
          core_addr[k*AW +: AW] = $urandom;
        end
      end
      ready = ($urandom_range(0, 3) != 0);
      rdv   = ($urandom_range(0, 9) < 4);
      rdata = {$urandom, $urandom, $urandom, $urandom};
      #1;
      if (cmd_valid && !prev_valid) begin
        w = rr(mptr, req_snap);
        total++; if (w < 0 || cmd_core !== 2'(w) || cmd_addr !== addr_snap[2'(w)*AW +: AW] || mout >= 16)
          begin bad++; $display("FAIL rnd_pick cyc=%0d got=%0d/%h exp=%0d/%h", cyc, cmd_core, cmd_addr, w, addr_snap[2'(w)*AW +: AW]); end
        cur_core = 2'(w); cur_addr = addr_snap[2'(w)*AW +: AW];
      end else if (cmd_valid) begin
        total++; if (cmd_core !== cur_core || cmd_addr !== cur_addr)
          begin bad++; $display("FAIL rnd_hold cyc=%0d got=%0d/%h exp=%0d/%h", cyc, cmd_core, cmd_addr, cur_core, cur_addr); end
      end
      exp_wr = cmd_valid && ready;
      total++; if (wr_en !== exp_wr || (exp_wr && wdata !== cur_core))
        begin bad++; $display("FAIL rnd_push cyc=%0d got=%0b/%0d exp=%0b/%0d", cyc, wr_en, wdata, exp_wr, cur_core); end
      exp_rd = rdv && (mq.size() > 0);
      total++; if (rd_en !== exp_rd) begin bad++; $display("FAIL rnd_pop cyc=%0d got=%0b exp=%0b", cyc, rd_en, exp_rd); end
      if (exp_rd) begin
        exp_rdv = 4'(1 << mq.pop_front());
        exp_rdata = rdata;
        mout--;
      end else begin
        exp_rdv = 4'b0;
        if (rdv) exp_err = 1'b1;
      end
      if (exp_wr) begin
        mq.push_back(cur_core);
        mptr = (int'(cur_core) + 1) % 4;
        mout++;
      end
      prev_acc = exp_wr;
      prev_valid = cmd_valid;
      req_snap = req; addr_snap = core_addr;
    end
    rdv = 1'b0; req = '0;
  endtask

  initial begin
    rst_n = 1'b0; req = '0; core_addr = '0; ready = 1'b0; rdv = 1'b0; rdata = '0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_backpressure();
    test_outstanding_limit();
    test_out_of_order();
    test_underflow_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/read_core_arbiter.md
# read_core_arbiter

Round-robin read-request arbiter and return router for the DRAM global controller. Accepts read requests from NUM_CORES cores, issues one read command at a time to the backend with a valid/ready handshake, and pushes the winning core number into the external read core-number FIFO in command order. On each returning read beat it pops that FIFO and steers the data-valid strobe to the originating core. It also tracks outstanding reads and flags returns that arrive with no matching entry.

## Interface
- NUM_CORES, 4, number of requesting cores
- CORE_ID_W, 2, core-number width; equals the FIFO's core_num_t width
- ADDR_W, 32, read address width
- DATA_W, 128, read data width
- FIFO_DEPTH, 4, log2 of core-number FIFO entries; outstanding limit is 2**FIFO_DEPTH

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_core_rd_req  in  NUM_CORES  per-core read request, level, held until granted
- i_core_rd_addr  in  NUM_CORES*ADDR_W  per-core address; core k occupies bits [k*ADDR_W +: ADDR_W]
- o_core_rd_gnt  out  NUM_CORES  one-hot, one-cycle grant pulse
- o_cmd_valid  out  1  backend read command valid
- i_cmd_ready  in  1  backend accepts command
- o_cmd_addr  out  ADDR_W  command address
- o_cmd_core  out  CORE_ID_W  core number of the current command
- o_fifo_wr_en  out  1  push to core-number FIFO
- o_fifo_wdata  out  CORE_ID_W  pushed core number, equal to o_cmd_core
- i_fifo_full  in  1  FIFO full, registered
- o_fifo_rd_en  out  1  pop core-number FIFO
- i_fifo_rdata  in  CORE_ID_W  FIFO head, combinational from the FIFO
- i_fifo_empty  in  1  FIFO empty, registered
- i_rdata_valid  in  1  backend read beat valid, cannot be stalled
- i_rdata  in  DATA_W  backend read data
- o_core_rdata_valid  out  NUM_CORES  one-hot per-core data valid
- o_core_rdata  out  DATA_W  read data broadcast to all cores
- o_outstanding  out  FIFO_DEPTH+1  issued reads not yet returned
- o_err_underflow  out  1  sticky: a return arrived while the FIFO was empty

## Operation
- FSM states: IDLE, ISSUE, GNT.
- IDLE exits to ISSUE when all of the following hold: any i_core_rd_req bit is set, i_fifo_full=0, and o_outstanding < 2**FIFO_DEPTH.
  - On that transition, register the winner w into o_cmd_core and its address into o_cmd_addr, and set o_cmd_valid=1.
- ISSUE holds o_cmd_valid, o_cmd_addr and o_cmd_core stable until i_cmd_ready=1. On acceptance:
  - o_fifo_wr_en=1 combinationally in that cycle, with o_fifo_wdata=o_cmd_core.
  - Go to GNT and clear o_cmd_valid.
- GNT lasts exactly one cycle. o_core_rd_gnt[w]=1 and no arbitration takes place. Next state is IDLE.
- Each core must drop or replace its request by the edge that ends GNT.
- Round-robin arbitration:
  - Pointer resets to 0.
  - Search order is ptr, ptr+1, … modulo NUM_CORES.
  - On acceptance, ptr <= (w+1) mod NUM_CORES.
  - Requests that change while in ISSUE do not alter w.
- Return path:
  - o_fifo_rd_en = i_rdata_valid & ~i_fifo_empty.
  - The next cycle, o_core_rdata_valid[i_fifo_rdata]=1 and o_core_rdata = i_rdata (both registered).
  - If i_rdata_valid=1 while i_fifo_empty=1: drop the beat, do not pop, set o_err_underflow=1 until reset.
- Outstanding counter:
  - +1 on command acceptance, −1 on a pop, unchanged when both occur in the same cycle.
  - Never wraps: issue is gated at the 2**FIFO_DEPTH limit, and there is no pop when the FIFO is empty.
- Reset (asynchronous, any time, including mid-ISSUE): state=IDLE, ptr=0.
  - All outputs 0: o_cmd_valid, o_cmd_addr, o_cmd_core, o_core_rd_gnt, o_core_rdata_valid, o_core_rdata, o_outstanding, o_err_underflow.
  - o_fifo_wr_en and o_fifo_rd_en are 0 because their inputs are 0.
  - An in-flight command is abandoned. The FIFO shares the same reset.

## Timing
- Request to o_cmd_valid: 1 cycle (request sampled in IDLE).
- Acceptance edge to grant: o_core_rd_gnt is high for the cycle after the acceptance edge.
- Minimum issue interval: 3 cycles (IDLE, ISSUE with ready=1, GNT).
- FIFO push happens at the acceptance edge. i_fifo_full is updated at that same edge, so IDLE always sees the current value.
- Return latency: i_rdata_valid to o_core_rdata_valid is 1 cycle. Back-to-back beats are supported at 1 per cycle.
- Simultaneous push and pop in one cycle is legal. Both take effect and o_outstanding is unchanged.

## Test plan
- Single read: core 2 raises a request with addr 0x100 and ready=1 → o_cmd_valid the next cycle, o_cmd_addr=0x100, o_cmd_core=2, o_fifo_wr_en for 1 cycle, gnt=4'b0100 one cycle later, o_outstanding=1. Then rdata_valid with data 0xAB → o_core_rdata_valid=4'b0100, o_core_rdata=0xAB, o_outstanding=0.
- Round-robin fairness: all 4 cores request continuously and re-request after each grant → grant order 0,1,2,3,0,1; no core granted twice before every other requester has been granted.
- Backpressure: i_cmd_ready=0 for 5 cycles → o_cmd_valid, o_cmd_addr and o_cmd_core stay stable, no push, no grant. Ready=1 → exactly one push and one grant.
- Outstanding limit: issue 16 reads with no returns → o_outstanding=16 and o_cmd_valid stays 0 while requests are pending. One return → issue resumes.
- Out-of-order sources: issue cores 3,1,0 in that order, then 3 returns → valid strobes go to 3,1,0 in order. Also cover a return in the same cycle as an acceptance (counter unchanged).
- Underflow and reset: rdata_valid with the FIFO empty → no pop, no core valid, o_err_underflow=1 and it stays set. Assert i_rst_n low during ISSUE → all outputs 0 immediately and the arbitration pointer restarts at core 0.
